// File: rtl/mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl
//   Control and adder stage of a sequential shift-add multiplier. It sequences
//   the external (2*WIDTH+1)-bit accumulator through load / add / shift steps,
//   forms the partial sum that the accumulator takes on 'ad', and returns the
//   2*WIDTH-bit product through a start/done handshake.
//
// Ports
//   clock        in   1          system clock, rising edge
//   rst          in   1          asynchronous, active-high reset
//   start        in   1          request, sampled only while idle
//   multiplicand in   WIDTH      operand A, latched when start is accepted
//   multiplier   in   WIDTH      operand B, passed straight through on lsbin
//   acc_in       in   2*WIDTH    accumulator output
//   load         out  1          accumulator control: acc <= {0, lsbin}
//   ad           out  1          accumulator control: upper part <= msbin
//   shift        out  1          accumulator control: logical shift right
//   lsbin        out  WIDTH      multiplier pass-through
//   msbin        out  WIDTH+1    upper accumulator half + latched multiplicand
//   busy         out  1          high in every state except idle
//   done         out  1          one-cycle pulse, product valid
//   product      out  2*WIDTH    result, held until the next completion
// -----------------------------------------------------------------------------
module mult_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [2*WIDTH-1:0] acc_in,
  output logic               load,
  output logic               ad,
  output logic               shift,
  output logic [WIDTH-1:0]   lsbin,
  output logic [WIDTH:0]     msbin,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [2*WIDTH-1:0] product_r;
  logic               done_r;
  logic               load_r;
  logic               ad_r;
  logic               shift_r;
  logic               busy_r;

  // Next-state decode for the sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_LOAD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD:  state_s = S_TEST;
      S_TEST: begin
        if (acc_in[0]) begin
          state_s = S_ADD;
        end else begin
          state_s = S_SHIFT;
        end
      end
      S_ADD:   state_s = S_SHIFT;
      S_SHIFT: begin
        if (cnt_r == CNT_LAST) begin
          state_s = S_DONE;
        end else begin
          state_s = S_TEST;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State register plus datapath registers. Controls are registered from the
  // next state so they line up with the state they belong to and are glitch-free.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      cnt_r     <= '0;
      mcand_r   <= '0;
      product_r <= '0;
      done_r    <= 1'b0;
      load_r    <= 1'b0;
      ad_r      <= 1'b0;
      shift_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      load_r  <= (state_s == S_LOAD);
      ad_r    <= (state_s == S_ADD);
      shift_r <= (state_s == S_SHIFT);
      busy_r  <= (state_s != S_IDLE);
      // done rises only on the DONE->IDLE edge, so it covers the first idle cycle.
      done_r  <= (state_r == S_DONE);
      if ((state_r == S_IDLE) && start) begin
        mcand_r <= multiplicand;
        cnt_r   <= '0;
      end else if (state_r == S_SHIFT) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (state_r == S_DONE) begin
        product_r <= acc_in;
      end else begin
        product_r <= product_r;
      end
    end
  end

  // Carry of the sum is kept; the accumulator holds it in its top bit until
  // the following shift moves it into the product field.
  assign msbin   = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
  assign lsbin   = multiplier;
  assign load    = load_r;
  assign ad      = ad_r;
  assign shift   = shift_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule
